clock_time_counter: RTL

Parametrised timekeeping core for the digital-clock datapath, driven by the 1 Hz tick and the mode FSM's `state` code. In run mode it counts seconds, minutes and hours with full carry. In set modes it freezes time and applies exactly one bidirectional, non-carrying adjustment per debounced-synchronised button press. It also provides a 12/24-hour display view, a PM flag and a midnight pulse for the downstream display and calendar blocks.

---
 rtl/clock_time_counter.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/clock_time_counter.sv
`default_nettype none
// ============================================================================
//  Module      : clock_time_counter
//  Description : Timekeeping core for the digital clock. Counts seconds,
//                minutes and hours with full carry in run mode; in the set
//                modes time is frozen and each synchronised button press
//                nudges one field up or down without carry. Also produces
//                a 12/24-hour display hour, a PM flag and a midnight pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module clock_time_counter #(
  parameter int SEC_W    = 6,
  parameter int MIN_W    = 6,
  parameter int HOUR_W   = 5,
  parameter int STATE_W  = 3,
  parameter int SEC_MAX  = 60,
  parameter int MIN_MAX  = 60,
  parameter int HOUR_MAX = 24
) (
  input  logic               clk_1Hz,
  input  logic               rst_n,
  input  logic [STATE_W-1:0] state,
  input  logic               set_n,
  input  logic               dir,
  input  logic               mode_12h,
  output logic [SEC_W-1:0]   seconds,
  output logic [MIN_W-1:0]   minutes,
  output logic [HOUR_W-1:0]  hours,
  output logic [HOUR_W-1:0]  hours_disp,
  output logic               pm,
  output logic               day_tick
);

  // Mode codes driven by the mode FSM; every other code counts like TIME_VIEW.
  localparam logic [STATE_W-1:0] c_st_set_hour   = STATE_W'(1);
  localparam logic [STATE_W-1:0] c_st_set_minute = STATE_W'(2);
  localparam logic [STATE_W-1:0] c_st_set_second = STATE_W'(3);

  // Last legal value of each field and the 12-hour split point.
  localparam logic [SEC_W-1:0]  c_sec_last  = SEC_W'(SEC_MAX - 1);
  localparam logic [MIN_W-1:0]  c_min_last  = MIN_W'(MIN_MAX - 1);
  localparam logic [HOUR_W-1:0] c_hour_last = HOUR_W'(HOUR_MAX - 1);
  localparam logic [HOUR_W-1:0] c_hour_half = HOUR_W'(HOUR_MAX / 2);

  // --------------------------------------------------------------------------
  // Button synchroniser and falling-edge detector
  // --------------------------------------------------------------------------
  logic r_s1;
  logic r_s2;
  logic r_s3;
  logic w_press;

  // Two-flop synchroniser plus one history flop; idle level is released (1).
  always_ff @(posedge clk_1Hz or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_s3 <= 1'b1;
    end else begin
      r_s1 <= set_n;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // A press is the single cycle where the synchronised level has just fallen;
  // holding the button low therefore never repeats the adjustment.
  assign w_press = r_s3 & ~r_s2;

  // --------------------------------------------------------------------------
  // Mode decode
  // --------------------------------------------------------------------------
  logic w_run;
  logic w_adj_hour;
  logic w_adj_min;
  logic w_adj_sec;

  // Decode the mode: set modes freeze time and route a press to one field.
  always_comb begin
    w_run      = 1'b0;
    w_adj_hour = 1'b0;
    w_adj_min  = 1'b0;
    w_adj_sec  = 1'b0;
    case (state)
      c_st_set_hour:   w_adj_hour = w_press;
      c_st_set_minute: w_adj_min  = w_press;
      c_st_set_second: w_adj_sec  = w_press;
      default:         w_run      = 1'b1;
    endcase
  end

  // --------------------------------------------------------------------------
  // Wrap detection; >= so a corrupted field recovers to 0 on its next update
  // --------------------------------------------------------------------------
  logic w_sec_wrap;
  logic w_min_wrap;
  logic w_hour_wrap;

  assign w_sec_wrap  = (seconds >= c_sec_last);
  assign w_min_wrap  = (minutes >= c_min_last);
  assign w_hour_wrap = (hours   >= c_hour_last);

  // --------------------------------------------------------------------------
  // Single-step increment / decrement of each field (no carry)
  // --------------------------------------------------------------------------
  logic [SEC_W-1:0]  w_sec_inc;
  logic [SEC_W-1:0]  w_sec_dec;
  logic [MIN_W-1:0]  w_min_inc;
  logic [MIN_W-1:0]  w_min_dec;
  logic [HOUR_W-1:0] w_hour_inc;
  logic [HOUR_W-1:0] w_hour_dec;

  // Increment wraps from the last value to 0; decrement wraps 0 to the last
  // value, and an out-of-range value is pulled back to 0.
  always_comb begin
    w_sec_inc  = w_sec_wrap  ? '0 : seconds + 1'b1;
    w_min_inc  = w_min_wrap  ? '0 : minutes + 1'b1;
    w_hour_inc = w_hour_wrap ? '0 : hours   + 1'b1;

    if (seconds == '0) begin
      w_sec_dec = c_sec_last;
    end else if (seconds > c_sec_last) begin
      w_sec_dec = '0;
    end else begin
      w_sec_dec = seconds - 1'b1;
    end

    if (minutes == '0) begin
      w_min_dec = c_min_last;
    end else if (minutes > c_min_last) begin
      w_min_dec = '0;
    end else begin
      w_min_dec = minutes - 1'b1;
    end

    if (hours == '0) begin
      w_hour_dec = c_hour_last;
    end else if (hours > c_hour_last) begin
      w_hour_dec = '0;
    end else begin
      w_hour_dec = hours - 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state selection
  // --------------------------------------------------------------------------
  logic [SEC_W-1:0]  w_sec_next;
  logic [MIN_W-1:0]  w_min_next;
  logic [HOUR_W-1:0] w_hour_next;
  logic              w_day_next;

  // Run mode ripples carries from current values in one cycle; set modes
  // only touch the selected field on a press.
  always_comb begin
    w_sec_next  = seconds;
    w_min_next  = minutes;
    w_hour_next = hours;
    w_day_next  = 1'b0;
    if (w_run) begin
      w_sec_next = w_sec_inc;
      if (w_sec_wrap) begin
        w_min_next = w_min_inc;
        if (w_min_wrap) begin
          w_hour_next = w_hour_inc;
          w_day_next  = w_hour_wrap;
        end
      end
    end else begin
      if (w_adj_sec) begin
        w_sec_next = dir ? w_sec_inc : w_sec_dec;
      end
      if (w_adj_min) begin
        w_min_next = dir ? w_min_inc : w_min_dec;
      end
      if (w_adj_hour) begin
        w_hour_next = dir ? w_hour_inc : w_hour_dec;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Time registers
  // --------------------------------------------------------------------------

  // Stored time and the registered midnight pulse.
  always_ff @(posedge clk_1Hz or negedge rst_n) begin
    if (!rst_n) begin
      seconds  <= '0;
      minutes  <= '0;
      hours    <= '0;
      day_tick <= 1'b0;
    end else begin
      seconds  <= w_sec_next;
      minutes  <= w_min_next;
      hours    <= w_hour_next;
      day_tick <= w_day_next;
    end
  end

  // --------------------------------------------------------------------------
  // Display view
  // --------------------------------------------------------------------------
  logic [HOUR_W-1:0] w_hour_mod;

  // Hours never exceed HOUR_MAX-1, so one conditional subtract gives the
  // hour modulo HOUR_MAX/2; a zero result is shown as HOUR_MAX/2 (12).
  always_comb begin
    pm         = (hours >= c_hour_half);
    w_hour_mod = pm ? (hours - c_hour_half) : hours;
    if (mode_12h) begin
      hours_disp = (w_hour_mod == '0) ? c_hour_half : w_hour_mod;
    end else begin
      hours_disp = hours;
    end
  end

endmodule
`default_nettype wire
